// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcodes and FSM encoding.
package instr_seq_pkg;
  localparam int DATA_W     = 2;
  localparam int INSTR_W    = 4;
  localparam int PROG_DEPTH = 4;
  localparam int ADDR_W     = 2;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;
endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: small register file, synchronous write, asynchronous read, cleared on reset.
module prog_mem
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = PROG_DEPTH,
  parameter int W     = INSTR_W,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXEC sequencer driving a small accumulator from the program store at address pc.
module instr_sequencer
  import instr_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              busy,
  output logic              halted,
  output logic              pc_advance
);
  // Handshake with the counter stage: pc_advance is a one-cycle request with no
  // back-pressure; the counter must step on the same edge that leaves EXEC so that
  // the following FETCH reads the new pc.
  state_t             state, next_state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] mem_rdata;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  imm_q;
  logic [DATA_W:0]    sum;
  logic               mem_we;

  // Program store may only change while no instruction is in flight.
  assign mem_we = prog_we && (state == ST_IDLE || state == ST_HALTED);

  prog_mem u_prog_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  assign sum = {1'b0, acc} + {1'b0, imm_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ir    <= '0;
      op_q  <= OP_NOP;
      imm_q <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH) ir <= mem_rdata;
      if (state == ST_DECODE) begin
        op_q  <= ir[INSTR_W-1 -: 2];
        imm_q <= ir[DATA_W-1:0];
      end
      if (state == ST_EXEC) begin
        case (op_q)
          OP_LDI: begin
            acc   <= imm_q;
            carry <= 1'b0;
          end
          OP_ADDI: {carry, acc} <= sum;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (run) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_HALT) next_state = ST_HALTED;
        else if (run)        next_state = ST_FETCH;
        else                 next_state = ST_IDLE;
      end
      ST_HALTED: if (!run) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign busy       = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign halted     = (state == ST_HALTED);
  assign pc_advance = (state == ST_EXEC) && (op_q != OP_HALT);
endmodule
